// File: rtl/stride_window_shift_register.sv
// Sliding-window shift register: fills SIZE entries, presents the window, and on ack
// retires a programmable stride of the oldest entries, which stream out on shift_out.
module stride_window_shift_register #(
    parameter int SIZE       = 3,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_STRIDE = 3
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               flush,
    input  logic [$clog2(MAX_STRIDE+1)-1:0]    stride,
    input  logic                               window_ack,
    output logic                               window_valid,
    output logic [SIZE*DATA_WIDTH-1:0]         data_out,
    output logic [DATA_WIDTH-1:0]              shift_out,
    output logic                               shift_out_valid,
    output logic [$clog2(SIZE+1)-1:0]          fill_count
);

    localparam int SW = $clog2(MAX_STRIDE + 1);
    localparam int CW = $clog2(SIZE + 1);

    localparam logic [0:0] ST_FILL   = 1'b0;
    localparam logic [0:0] ST_WINDOW = 1'b1;

    logic [DATA_WIDTH-1:0] r_entry [SIZE];
    logic [DATA_WIDTH-1:0] r_shift_out;
    logic                  r_shift_out_valid;
    logic [CW-1:0]         r_fill_count;
    logic                  r_primed;

    logic [0:0]            w_state;
    logic                  w_accept;
    logic                  w_ack;
    logic [CW-1:0]         w_eff_stride;

    // Zero stride means 1; anything beyond the window depth retires the whole window.
    function automatic logic [CW-1:0] eff_stride(input logic [SW-1:0] s);
        if (s == '0)
            return CW'(1);
        else if (int'(s) > SIZE)
            return CW'(SIZE);
        else
            return CW'(s);
    endfunction

    assign w_state      = (r_fill_count == CW'(SIZE)) ? ST_WINDOW : ST_FILL;
    assign window_valid = (w_state == ST_WINDOW);
    assign in_ready     = (w_state == ST_FILL) && !flush;
    assign w_accept     = in_valid && in_ready;
    assign w_ack        = window_ack && (w_state == ST_WINDOW);
    assign w_eff_stride = eff_stride(stride);

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            for (int i = 0; i < SIZE; i++)
                r_entry[i] <= '0;
            r_shift_out       <= '0;
            r_shift_out_valid <= 1'b0;
            r_fill_count      <= '0;
            r_primed          <= 1'b0;
        end else begin
            r_shift_out_valid <= w_accept && r_primed;
            if (w_ack) begin
                r_fill_count <= CW'(SIZE) - w_eff_stride;
                r_primed     <= 1'b1;
            end else if (w_accept) begin
                for (int i = SIZE - 1; i > 0; i--)
                    r_entry[i] <= r_entry[i-1];
                r_entry[0]   <= in_data;
                r_shift_out  <= r_entry[SIZE-1];
                r_fill_count <= r_fill_count + CW'(1);
            end
        end
    end

    always_comb begin
        data_out = '0;
        for (int i = 0; i < SIZE; i++)
            data_out[i*DATA_WIDTH +: DATA_WIDTH] = r_entry[i];
    end

    assign shift_out       = r_shift_out;
    assign shift_out_valid = r_shift_out_valid;
    assign fill_count      = r_fill_count;

endmodule

// File: tb/tb_stride_window_shift_register.sv
// Directed bench for stride_window_shift_register with SIZE=3, DATA_WIDTH=32, MAX_STRIDE=3.
module tb_stride_window_shift_register;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        flush;
    logic [1:0]  stride;
    logic        window_ack;
    logic        window_valid;
    logic [95:0] data_out;
    logic [31:0] shift_out;
    logic        shift_out_valid;
    logic [1:0]  fill_count;

    int checks = 0;
    int errors = 0;

    stride_window_shift_register #(.SIZE(3), .DATA_WIDTH(32), .MAX_STRIDE(3)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .stride(stride), .window_ack(window_ack),
        .window_valid(window_valid), .data_out(data_out), .shift_out(shift_out),
        .shift_out_valid(shift_out_valid), .fill_count(fill_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        in_valid = 1'b1;
        in_data  = d;
        step();
        in_valid = 1'b0;
    endtask

    task automatic ack(input logic [1:0] s);
        window_ack = 1'b1;
        stride     = s;
        step();
        window_ack = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        checks++; if (fill_count !== 2'd0) begin errors++; $display("FAIL reset_fill got %0d exp 0", fill_count); end
        checks++; if (window_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_hs got wv=%b rdy=%b exp wv=0 rdy=1", window_valid, in_ready); end
        checks++; if (data_out !== 96'd0 || shift_out !== 32'd0 || shift_out_valid !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%h/%b exp 0", data_out, shift_out, shift_out_valid); end
    endtask

    task automatic test_fill();
        logic [31:0] vals [3] = '{32'd1, 32'd2, 32'd3};
        for (int i = 0; i < 3; i++) begin
            push(vals[i]);
            checks++; if (shift_out_valid !== 1'b0) begin errors++; $display("FAIL fill_sov%0d got %b exp 0", i, shift_out_valid); end
            checks++; if (fill_count !== 2'(i + 1)) begin errors++; $display("FAIL fill_cnt%0d got %0d exp %0d", i, fill_count, i + 1); end
        end
        checks++; if (window_valid !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_hs got wv=%b rdy=%b exp wv=1 rdy=0", window_valid, in_ready); end
        checks++; if (data_out !== {32'd1, 32'd2, 32'd3}) begin errors++; $display("FAIL fill_data got %h exp %h", data_out, {32'd1, 32'd2, 32'd3}); end
    endtask

    task automatic test_stride1();
        ack(2'd1);
        checks++; if (fill_count !== 2'd2 || window_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL s1_ack got cnt=%0d wv=%b rdy=%b exp 2/0/1", fill_count, window_valid, in_ready); end
        checks++; if (data_out !== {32'd1, 32'd2, 32'd3}) begin errors++; $display("FAIL s1_keep got %h exp %h", data_out, {32'd1, 32'd2, 32'd3}); end
        push(32'd4);
        checks++; if (shift_out_valid !== 1'b1 || shift_out !== 32'd1) begin errors++; $display("FAIL s1_shift got v=%b d=%0d exp v=1 d=1", shift_out_valid, shift_out); end
        checks++; if (fill_count !== 2'd3 || data_out !== {32'd2, 32'd3, 32'd4}) begin errors++; $display("FAIL s1_win got cnt=%0d %h exp 3 %h", fill_count, data_out, {32'd2, 32'd3, 32'd4}); end
        step();
        checks++; if (shift_out_valid !== 1'b0) begin errors++; $display("FAIL s1_pulse got %b exp 0", shift_out_valid); end
    endtask

    task automatic test_stride3();
        logic [31:0] ins  [3] = '{32'd5, 32'd6, 32'd7};
        logic [31:0] outs [3] = '{32'd2, 32'd3, 32'd4};
        ack(2'd3);
        checks++; if (fill_count !== 2'd0) begin errors++; $display("FAIL s3_ack got %0d exp 0", fill_count); end
        for (int i = 0; i < 3; i++) begin
            push(ins[i]);
            checks++; if (shift_out_valid !== 1'b1 || shift_out !== outs[i]) begin errors++; $display("FAIL s3_shift%0d got v=%b d=%0d exp v=1 d=%0d", i, shift_out_valid, shift_out, outs[i]); end
        end
        checks++; if (window_valid !== 1'b1 || data_out !== {32'd5, 32'd6, 32'd7}) begin errors++; $display("FAIL s3_win got wv=%b %h exp 1 %h", window_valid, data_out, {32'd5, 32'd6, 32'd7}); end
    endtask

    task automatic test_stride0();
        ack(2'd0);
        checks++; if (fill_count !== 2'd2) begin errors++; $display("FAIL s0_ack got %0d exp 2", fill_count); end
        push(32'd8);
        checks++; if (window_valid !== 1'b1 || data_out !== {32'd6, 32'd7, 32'd8}) begin errors++; $display("FAIL s0_win got wv=%b %h exp 1 %h", window_valid, data_out, {32'd6, 32'd7, 32'd8}); end
        checks++; if (shift_out_valid !== 1'b1 || shift_out !== 32'd5) begin errors++; $display("FAIL s0_shift got v=%b d=%0d exp v=1 d=5", shift_out_valid, shift_out); end
    endtask

    task automatic test_hold();
        in_valid = 1'b1;
        in_data  = 32'd9;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (data_out !== {32'd6, 32'd7, 32'd8} || fill_count !== 2'd3 || shift_out_valid !== 1'b0) begin errors++; $display("FAIL hold%0d got %h cnt=%0d v=%b exp %h 3 0", i, data_out, fill_count, shift_out_valid, {32'd6, 32'd7, 32'd8}); end
        end
        ack(2'd1);
        checks++; if (fill_count !== 2'd2 || in_ready !== 1'b1) begin errors++; $display("FAIL hold_ack got cnt=%0d rdy=%b exp 2 1", fill_count, in_ready); end
        step();
        in_valid = 1'b0;
        checks++; if (data_out !== {32'd7, 32'd8, 32'd9} || shift_out !== 32'd6 || shift_out_valid !== 1'b1) begin errors++; $display("FAIL hold_acc got %h d=%0d v=%b exp %h 6 1", data_out, shift_out, shift_out_valid, {32'd7, 32'd8, 32'd9}); end
    endtask

    task automatic test_flush_reset();
        ack(2'd1);
        window_ack = 1'b1;
        stride     = 2'd3;
        step();
        window_ack = 1'b0;
        checks++; if (fill_count !== 2'd2) begin errors++; $display("FAIL ack_in_fill got %0d exp 2", fill_count); end
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'd10;
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_rdy got %b exp 0", in_ready); end
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        checks++; if (fill_count !== 2'd0 || data_out !== 96'd0 || shift_out !== 32'd0 || shift_out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_state got cnt=%0d %h d=%0d v=%b rdy=%b exp all 0 rdy=1", fill_count, data_out, shift_out, shift_out_valid, in_ready); end
        for (int i = 0; i < 3; i++) begin
            push(32'(11 + i));
            checks++; if (shift_out_valid !== 1'b0) begin errors++; $display("FAIL flush_unprimed%0d got %b exp 0", i, shift_out_valid); end
        end
        checks++; if (window_valid !== 1'b1 || data_out !== {32'd11, 32'd12, 32'd13}) begin errors++; $display("FAIL flush_refill got wv=%b %h exp 1 %h", window_valid, data_out, {32'd11, 32'd12, 32'd13}); end
        reset      = 1'b1;
        window_ack = 1'b1;
        stride     = 2'd1;
        step();
        reset      = 1'b0;
        window_ack = 1'b0;
        #1;
        checks++; if (fill_count !== 2'd0 || window_valid !== 1'b0 || in_ready !== 1'b1 || data_out !== 96'd0 || shift_out !== 32'd0 || shift_out_valid !== 1'b0) begin errors++; $display("FAIL rst_win got cnt=%0d wv=%b rdy=%b %h d=%0d v=%b exp 0 0 1 0 0 0", fill_count, window_valid, in_ready, data_out, shift_out, shift_out_valid); end
        for (int i = 0; i < 3; i++) begin
            push(32'(14 + i));
            checks++; if (shift_out_valid !== 1'b0) begin errors++; $display("FAIL rst_unprimed%0d got %b exp 0", i, shift_out_valid); end
        end
        checks++; if (data_out !== {32'd14, 32'd15, 32'd16} || fill_count !== 2'd3) begin errors++; $display("FAIL rst_refill got %h cnt=%0d exp %h 3", data_out, fill_count, {32'd14, 32'd15, 32'd16}); end
    endtask

    initial begin
        reset      = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        flush      = 1'b0;
        stride     = '0;
        window_ack = 1'b0;
        test_reset();
        test_fill();
        test_stride1();
        test_stride3();
        test_stride0();
        test_hold();
        test_flush_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
